bsg_bladerunner_cfg_mem: RTL and testbench

- Configuration/ID memory slave for the manycore network: read-only ROM region plus a small writable scratch-register region, addressed by word.
- Sits behind a manycore endpoint. Consumes decoupled requests and returns exactly one in-order response per request.
- Generalises the single-cycle read-only config ROM:
  - configurable read latency;
  - masked writes to scratch;
  - response buffering with backpressure;
  - error accounting instead of simulation abort on writes.

---
 rtl/bsg_bladerunner_cfg_mem_pkg.sv | 26 ++
 rtl/bsg_fifo_1r1w_small.sv | 53 +++++
 rtl/bsg_bladerunner_cfg_mem.sv | 180 ++++++++++++++++++
 tb/tb_bsg_bladerunner_cfg_mem.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_bladerunner_cfg_mem_pkg.sv
// Shared types for the configuration/ID memory slave: address region
// classification, the response record carried through the response
// pipeline, and the ROM address width helper.
package bsg_bladerunner_cfg_mem_pkg;

  typedef enum logic [1:0] {
    e_cfg_rom,
    e_cfg_scratch,
    e_cfg_none
  } cfg_region_e;

  // Widest link data the response record can carry.
  localparam int cfg_max_data_width_gp = 64;

  typedef struct packed {
    logic                             we;
    logic                             err;
    logic [cfg_max_data_width_gp-1:0] data;
  } cfg_resp_s;

  // ROM address width, at least one bit even for a single-word ROM.
  function automatic int cfg_rom_addr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with registered storage; an entry written
// at a clock edge is visible at data_o in the following cycle.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, rptr_q;
  logic [cnt_w_lp-1:0] count_q;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign ready_o = (count_q != cnt_w_lp'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wptr_q <= ptr_inc(wptr_q);
      if (deq) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  // Entry storage; contents only matter while counted as valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_bladerunner_cfg_mem.sv
// Configuration/ID memory slave: external combinational ROM plus a small
// byte-writable scratch region. Requests are decoded and answered in order
// after read_latency_p cycles; responses queue in a credit-managed buffer.
module bsg_bladerunner_cfg_mem
  import bsg_bladerunner_cfg_mem_pkg::*;
#(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int rom_width_p    = 32,
  parameter int rom_els_p      = 64,
  parameter int scratch_base_p = 1024,
  parameter int scratch_els_p  = 8,
  parameter int read_latency_p = 1,
  parameter int fifo_els_p     = 4,
  parameter int err_width_p    = 8
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      req_v_i,
  output logic                                      req_ready_o,
  input  logic                                      req_we_i,
  input  logic [addr_width_p-1:0]                   req_addr_i,
  input  logic [data_width_p-1:0]                   req_data_i,
  input  logic [data_width_p/8-1:0]                 req_mask_i,
  output logic [cfg_rom_addr_width(rom_els_p)-1:0]  rom_addr_o,
  input  logic [rom_width_p-1:0]                    rom_data_i,
  output logic                                      resp_v_o,
  output logic                                      resp_we_o,
  output logic [data_width_p-1:0]                   resp_data_o,
  output logic                                      resp_err_o,
  input  logic                                      resp_yumi_i,
  output logic [err_width_p-1:0]                    err_count_o
);

  localparam int mask_w_lp     = data_width_p / 8;
  localparam int rom_addr_w_lp = cfg_rom_addr_width(rom_els_p);
  localparam int sidx_w_lp     = (scratch_els_p > 1) ? $clog2(scratch_els_p) : 1;
  localparam int occ_w_lp      = $clog2(fifo_els_p + 1);

  function automatic logic [data_width_p-1:0] expand_mask(input logic [mask_w_lp-1:0] m);
    logic [data_width_p-1:0] r;
    r = '0;
    for (int b = 0; b < mask_w_lp; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  logic [occ_w_lp-1:0]     occ_q, occ_d;
  logic [err_width_p-1:0]  err_cnt_q, err_cnt_d;
  logic [data_width_p-1:0] scratch_q [scratch_els_p];
  logic                    accept, yumi_eff, illegal_p0, scratch_we;
  cfg_region_e             region_p0;
  logic [sidx_w_lp-1:0]    sidx_p0;
  logic [data_width_p-1:0] rd_raw_p0, mask_bits_p0;
  cfg_resp_s               resp_p0;
  cfg_resp_s               fifo_data_li, fifo_data_lo;
  logic                    fifo_v_li, fifo_v_lo, fifo_ready_lo;

  // Credits: every accepted request holds a slot until its response is taken,
  // so the buffer can never overflow and the pipeline never needs to stall.
  assign req_ready_o = ~reset_i & (occ_q < occ_w_lp'(fifo_els_p));
  assign accept      = req_v_i & req_ready_o;
  assign yumi_eff    = resp_yumi_i & resp_v_o;
  assign occ_d       = occ_q + occ_w_lp'(accept) - occ_w_lp'(yumi_eff);

  assign rom_addr_o   = rom_addr_w_lp'(req_addr_i);
  assign sidx_p0      = sidx_w_lp'(req_addr_i - addr_width_p'(scratch_base_p));
  assign mask_bits_p0 = expand_mask(req_mask_i);

  // Stage 0: classify the request address.
  always_comb begin
    region_p0 = e_cfg_none;
    if (req_addr_i < addr_width_p'(rom_els_p))
      region_p0 = e_cfg_rom;
    else if ((req_addr_i >= addr_width_p'(scratch_base_p)) &&
             (req_addr_i <  addr_width_p'(scratch_base_p + scratch_els_p)))
      region_p0 = e_cfg_scratch;
  end

  assign illegal_p0 = (region_p0 == e_cfg_none) | ((region_p0 == e_cfg_rom) & req_we_i);
  assign scratch_we = accept & req_we_i & (region_p0 == e_cfg_scratch);

  // Stage 0: build the response record from the current ROM/scratch contents.
  always_comb begin
    rd_raw_p0 = '0;
    if (region_p0 == e_cfg_rom)          rd_raw_p0 = data_width_p'(rom_data_i);
    else if (region_p0 == e_cfg_scratch) rd_raw_p0 = scratch_q[sidx_p0];
    resp_p0     = '0;
    resp_p0.we  = req_we_i;
    resp_p0.err = illegal_p0;
    if (!req_we_i && !illegal_p0)
      resp_p0.data = cfg_max_data_width_gp'(rd_raw_p0 & mask_bits_p0);
  end

  // Scratch registers commit masked bytes at the accept edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < scratch_els_p; i++) scratch_q[i] <= '0;
    end else if (scratch_we) begin
      for (int b = 0; b < mask_w_lp; b++)
        if (req_mask_i[b]) scratch_q[sidx_p0][b*8 +: 8] <= req_data_i[b*8 +: 8];
    end
  end

  assign err_cnt_d = (accept & illegal_p0 & ~(&err_cnt_q)) ? err_cnt_q + err_width_p'(1)
                                                           : err_cnt_q;

  // Credit occupancy and saturating error counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      occ_q     <= occ_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Stage 1 (two-cycle latency only): one extra register ahead of the buffer.
  if (read_latency_p == 2) begin : g_lat2
    logic      vld_p1_q;
    cfg_resp_s resp_p1_q;
    // Extra pipeline register; cleared on reset so nothing in flight survives.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        vld_p1_q  <= 1'b0;
        resp_p1_q <= '0;
      end else begin
        vld_p1_q  <= accept;
        resp_p1_q <= resp_p0;
      end
    end
    assign fifo_v_li    = vld_p1_q;
    assign fifo_data_li = resp_p1_q;
  end else begin : g_lat1
    assign fifo_v_li    = accept;
    assign fifo_data_li = resp_p0;
  end

  bsg_fifo_1r1w_small #(
    .width_p ($bits(cfg_resp_s)),
    .els_p   (fifo_els_p)
  ) resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (fifo_v_li),
    .ready_o (fifo_ready_lo),
    .data_i  (fifo_data_li),
    .v_o     (fifo_v_lo),
    .data_o  (fifo_data_lo),
    .yumi_i  (yumi_eff)
  );

  assign resp_v_o    = fifo_v_lo;
  assign resp_we_o   = fifo_v_lo & fifo_data_lo.we;
  assign resp_err_o  = fifo_v_lo & fifo_data_lo.err;
  assign resp_data_o = fifo_v_lo ? fifo_data_lo.data[data_width_p-1:0] : '0;
  assign err_count_o = err_cnt_q;

`ifndef SYNTHESIS
  localparam bit params_ok_lp =
    (data_width_p % 8 == 0) && (data_width_p <= cfg_max_data_width_gp) &&
    (rom_width_p <= data_width_p) && (scratch_base_p >= rom_els_p) &&
    (scratch_els_p >= 1) && (read_latency_p == 1 || read_latency_p == 2) &&
    (fifo_els_p >= read_latency_p + 1);

  // Simulation checks: legal configuration and well-behaved consumer.
  always_ff @(posedge clk_i) begin
    assert (params_ok_lp) else $error("bsg_bladerunner_cfg_mem: illegal parameters");
    if (!reset_i) begin
      assert (!(resp_yumi_i && !resp_v_o))
        else $error("bsg_bladerunner_cfg_mem: resp_yumi_i with no valid response");
      assert (!fifo_v_li || fifo_ready_lo)
        else $error("bsg_bladerunner_cfg_mem: response buffer overflow");
      assert (!fifo_v_lo || ((fifo_data_lo.data >> data_width_p) == '0))
        else $error("bsg_bladerunner_cfg_mem: response data wider than link");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_bladerunner_cfg_mem.sv
// Directed bench: instance A uses default parameters, instance B uses
// two-cycle read latency and a 2-bit error counter.
module tb_bsg_bladerunner_cfg_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst, a_req_v, a_req_we, a_req_ready, a_resp_v, a_resp_we, a_resp_err;
  logic        a_resp_yumi, a_yumi_en;
  logic [27:0] a_req_addr;
  logic [31:0] a_req_data, a_rom_data, a_resp_data;
  logic [3:0]  a_req_mask;
  logic [5:0]  a_rom_addr;
  logic [7:0]  a_err_count;

  logic        b_rst, b_req_v, b_req_we, b_req_ready, b_resp_v, b_resp_we, b_resp_err;
  logic        b_resp_yumi, b_yumi_en;
  logic [27:0] b_req_addr;
  logic [31:0] b_req_data, b_rom_data, b_resp_data;
  logic [3:0]  b_req_mask;
  logic [5:0]  b_rom_addr;
  logic [1:0]  b_err_count;

  assign a_rom_data  = 32'hA000_0000 + {26'd0, a_rom_addr};
  assign b_rom_data  = 32'hA000_0000 + {26'd0, b_rom_addr};
  assign a_resp_yumi = a_yumi_en & a_resp_v;
  assign b_resp_yumi = b_yumi_en & b_resp_v;

  bsg_bladerunner_cfg_mem dut_a (
    .clk_i(clk), .reset_i(a_rst), .req_v_i(a_req_v), .req_ready_o(a_req_ready),
    .req_we_i(a_req_we), .req_addr_i(a_req_addr), .req_data_i(a_req_data),
    .req_mask_i(a_req_mask), .rom_addr_o(a_rom_addr), .rom_data_i(a_rom_data),
    .resp_v_o(a_resp_v), .resp_we_o(a_resp_we), .resp_data_o(a_resp_data),
    .resp_err_o(a_resp_err), .resp_yumi_i(a_resp_yumi), .err_count_o(a_err_count)
  );

  bsg_bladerunner_cfg_mem #(.read_latency_p(2), .err_width_p(2)) dut_b (
    .clk_i(clk), .reset_i(b_rst), .req_v_i(b_req_v), .req_ready_o(b_req_ready),
    .req_we_i(b_req_we), .req_addr_i(b_req_addr), .req_data_i(b_req_data),
    .req_mask_i(b_req_mask), .rom_addr_o(b_rom_addr), .rom_data_i(b_rom_data),
    .resp_v_o(b_resp_v), .resp_we_o(b_resp_we), .resp_data_o(b_resp_data),
    .resp_err_o(b_resp_err), .resp_yumi_i(b_resp_yumi), .err_count_o(b_err_count)
  );

  task automatic drive_a(input logic v, input logic we, input logic [27:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
    a_req_v = v; a_req_we = we; a_req_addr = addr; a_req_data = data; a_req_mask = mask;
  endtask

  task automatic drive_b(input logic v, input logic we, input logic [27:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
    b_req_v = v; b_req_we = we; b_req_addr = addr; b_req_data = data; b_req_mask = mask;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; a_yumi_en = 1'b0; b_yumi_en = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_a got=%b exp=0", a_req_ready); end
    checks++; if (a_resp_v !== 1'b0) begin errors++; $display("FAIL reset_resp_v_a got=%b exp=0", a_resp_v); end
    checks++; if (a_err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt_a got=%0d exp=0", a_err_count); end
    checks++; if (b_req_ready !== 1'b0 || b_resp_v !== 1'b0) begin errors++; $display("FAIL reset_b ready=%b v=%b exp=0/0", b_req_ready, b_resp_v); end
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready_a got=%b exp=1", a_req_ready); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready_b got=%b exp=1", b_req_ready); end
    checks++; if (a_resp_data !== 32'd0 || a_resp_we !== 1'b0 || a_resp_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_fields_a data=%h we=%b err=%b exp=0", a_resp_data, a_resp_we, a_resp_err); end
  endtask

  task automatic test_rom_read();
    logic [27:0] addrs [3];
    logic [31:0] exp [3];
    addrs = '{28'd0, 28'd5, 28'd63};
    exp   = '{32'hA000_0000, 32'hA000_0005, 32'hA000_003F};
    a_yumi_en = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (a_resp_v !== 1'b1 || a_resp_data !== exp[i-1] || a_resp_err !== 1'b0 || a_resp_we !== 1'b0) begin
          errors++; $display("FAIL rom_read[%0d] v=%b data=%h err=%b exp v=1 data=%h err=0", i-1, a_resp_v, a_resp_data, a_resp_err, exp[i-1]);
        end
      end
      if (i < 3) drive_a(1, 0, addrs[i], 0, 4'hF);
      else       drive_a(0, 0, 0, 0, 0);
    end
    @(negedge clk);
    checks++; if (a_resp_v !== 1'b0) begin errors++; $display("FAIL rom_read_drained got=%b exp=0", a_resp_v); end
    a_yumi_en = 1'b0;
  endtask

  task automatic test_scratch();
    a_yumi_en = 1'b1;
    @(negedge clk);
    drive_a(1, 1, 28'd1027, 32'hDEAD_BEEF, 4'h5);
    @(negedge clk);
    checks++; if (a_resp_v !== 1'b1 || a_resp_we !== 1'b1 || a_resp_err !== 1'b0 || a_resp_data !== 32'd0) begin
      errors++; $display("FAIL scratch_ack v=%b we=%b err=%b data=%h exp 1/1/0/0", a_resp_v, a_resp_we, a_resp_err, a_resp_data); end
    drive_a(1, 0, 28'd1027, 0, 4'hF);
    @(negedge clk);
    checks++; if (a_resp_v !== 1'b1 || a_resp_we !== 1'b0 || a_resp_err !== 1'b0 || a_resp_data !== 32'h00AD_00EF) begin
      errors++; $display("FAIL scratch_read v=%b we=%b err=%b data=%h exp data=00ad00ef", a_resp_v, a_resp_we, a_resp_err, a_resp_data); end
    drive_a(1, 0, 28'd1027, 0, 4'h1);
    @(negedge clk);
    checks++; if (a_resp_data !== 32'h0000_00EF) begin
      errors++; $display("FAIL scratch_read_masked data=%h exp=000000ef", a_resp_data); end
    drive_a(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (a_resp_v !== 1'b0) begin errors++; $display("FAIL scratch_drained got=%b exp=0", a_resp_v); end
    a_yumi_en = 1'b0;
  endtask

  task automatic test_illegal();
    logic        we_in [4];
    logic [27:0] addr_in [4];
    logic        exp_err [4];
    logic [31:0] exp_data [4];
    we_in    = '{1'b1, 1'b0, 1'b1, 1'b0};
    addr_in  = '{28'd3, 28'd512, 28'd1032, 28'd3};
    exp_err  = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_data = '{32'd0, 32'd0, 32'd0, 32'hA000_0003};
    a_yumi_en = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (a_resp_v !== 1'b1 || a_resp_err !== exp_err[i-1] || a_resp_we !== we_in[i-1] || a_resp_data !== exp_data[i-1]) begin
          errors++; $display("FAIL illegal[%0d] v=%b err=%b we=%b data=%h exp err=%b we=%b data=%h",
                             i-1, a_resp_v, a_resp_err, a_resp_we, a_resp_data, exp_err[i-1], we_in[i-1], exp_data[i-1]);
        end
      end
      if (i < 4) drive_a(1, we_in[i], addr_in[i], 32'h1234_5678, 4'hF);
      else       drive_a(0, 0, 0, 0, 0);
    end
    @(negedge clk);
    checks++; if (a_err_count !== 8'd3) begin errors++; $display("FAIL illegal_errcnt got=%0d exp=3", a_err_count); end
    checks++; if (a_resp_v !== 1'b0) begin errors++; $display("FAIL illegal_drained got=%b exp=0", a_resp_v); end
    a_yumi_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int   idx, rcv;
    logic popped_full;
    a_yumi_en = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a_req_ready && idx < 6) begin drive_a(1, 0, 28'(10 + idx), 0, 4'hF); idx++; end
      else drive_a(0, 0, 0, 0, 0);
    end
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", idx); end
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", a_req_ready); end
    checks++; if (a_resp_v !== 1'b1 || a_resp_data !== 32'hA000_000A) begin
      errors++; $display("FAIL bp_head v=%b data=%h exp 1/a000000a", a_resp_v, a_resp_data); end
    rcv = 0;
    popped_full = 1'b0;
    for (int c = 0; c < 30 && rcv < 6; c++) begin
      @(negedge clk);
      if (popped_full) begin
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_restore got=%b exp=1", a_req_ready); end
        popped_full = 1'b0;
      end
      if (a_resp_v) begin
        checks++; if (a_resp_data !== 32'hA000_000A + 32'(rcv) || a_resp_err !== 1'b0) begin
          errors++; $display("FAIL bp_order[%0d] data=%h err=%b exp=%h", rcv, a_resp_data, a_resp_err, 32'hA000_000A + 32'(rcv)); end
        rcv++;
        popped_full = !a_req_ready;
      end
      a_yumi_en = 1'b1;
      if (a_req_ready && idx < 6) begin drive_a(1, 0, 28'(10 + idx), 0, 4'hF); idx++; end
      else drive_a(0, 0, 0, 0, 0);
    end
    @(negedge clk);
    a_yumi_en = 1'b0;
    checks++; if (rcv != 6 || idx != 6) begin errors++; $display("FAIL bp_count rcv=%0d sent=%0d exp=6/6", rcv, idx); end
    checks++; if (a_resp_v !== 1'b0) begin errors++; $display("FAIL bp_extra got=%b exp=0", a_resp_v); end
  endtask

  task automatic test_latency2();
    logic [27:0] addrs [3];
    logic [31:0] exp [3];
    addrs = '{28'd0, 28'd5, 28'd63};
    exp   = '{32'hA000_0000, 32'hA000_0005, 32'hA000_003F};
    b_yumi_en = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i < 3) begin
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL lat2_ready[%0d] got=%b exp=1", i, b_req_ready); end
      end
      if (i == 1 || i == 5) begin
        checks++; if (b_resp_v !== 1'b0) begin errors++; $display("FAIL lat2_idle[%0d] got=%b exp=0", i, b_resp_v); end
      end
      if (i >= 2 && i <= 4) begin
        checks++; if (b_resp_v !== 1'b1 || b_resp_data !== exp[i-2] || b_resp_err !== 1'b0) begin
          errors++; $display("FAIL lat2_data[%0d] v=%b data=%h exp=%h", i-2, b_resp_v, b_resp_data, exp[i-2]); end
      end
      if (i < 3) drive_b(1, 0, addrs[i], 0, 4'hF);
      else       drive_b(0, 0, 0, 0, 0);
    end
    b_yumi_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int got;
    b_yumi_en = 1'b0;
    @(negedge clk); drive_b(1, 1, 28'd1024, 32'h1122_3344, 4'hF);
    @(negedge clk); drive_b(1, 0, 28'd512, 0, 4'hF);
    @(negedge clk); drive_b(1, 0, 28'd1, 0, 4'hF);
    @(negedge clk); drive_b(1, 0, 28'd2, 0, 4'hF);
    @(negedge clk);
    checks++; if (b_resp_v !== 1'b1 || b_resp_we !== 1'b1 || b_req_ready !== 1'b0 || b_err_count !== 2'd1) begin
      errors++; $display("FAIL mid_before v=%b we=%b ready=%b errcnt=%0d exp 1/1/0/1", b_resp_v, b_resp_we, b_req_ready, b_err_count); end
    b_rst = 1'b1;
    drive_b(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (b_resp_v !== 1'b0 || b_err_count !== 2'd0 || b_req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset v=%b errcnt=%0d ready=%b exp 0/0/0", b_resp_v, b_err_count, b_req_ready); end
    b_rst = 1'b0;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b_resp_v) begin
        got++;
        checks++; if (b_resp_data !== 32'd0 || b_resp_we !== 1'b0 || b_resp_err !== 1'b0) begin
          errors++; $display("FAIL mid_after data=%h we=%b err=%b exp 0/0/0", b_resp_data, b_resp_we, b_resp_err); end
      end
      b_yumi_en = 1'b1;
      if (c == 0) drive_b(1, 0, 28'd1024, 0, 4'hF);
      else        drive_b(0, 0, 0, 0, 0);
    end
    checks++; if (got != 1) begin errors++; $display("FAIL mid_resp_count got=%0d exp=1", got); end
    b_yumi_en = 1'b0;
  endtask

  task automatic test_saturation();
    int got;
    got = 0;
    b_yumi_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b_resp_v) begin
        got++;
        checks++; if (b_resp_err !== 1'b1 || b_resp_we !== 1'b1 || b_resp_data !== 32'd0) begin
          errors++; $display("FAIL sat_resp[%0d] err=%b we=%b data=%h exp 1/1/0", got, b_resp_err, b_resp_we, b_resp_data); end
      end
      if (c < 5) drive_b(1, 1, 28'(c), 32'hFFFF_FFFF, 4'hF);
      else       drive_b(0, 0, 0, 0, 0);
    end
    checks++; if (got != 5) begin errors++; $display("FAIL sat_count got=%0d exp=5", got); end
    checks++; if (b_err_count !== 2'd3) begin errors++; $display("FAIL sat_errcnt got=%0d exp=3", b_err_count); end
    b_yumi_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_scratch();
    test_illegal();
    test_backpressure();
    test_latency2();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached before end of sequence");
    $fatal(1);
  end

endmodule
